control_pipe_gen: RTL

// - Next-generation control generator for the pipelined core. Decodes opcode_d/funct3_d into a full
//   9-bit control bundle and carries it down NUM_STAGES registered pipeline stages (D->E->M->W).
// - Supports valid/ready input, stall, flush, illegal-opcode detection and a saturating illegal counter.
// - Keeps the legacy 2-bit U_control encoding (00 JAL/JALR/other, 01 LUI, 10 AUIPC) as u_control_e.

---
 rtl/control_pipe_gen_pkg.sv | 51 +++++
 rtl/control_pipe_gen_if.sv | 11 +
 rtl/control_pipe_gen_decode.sv | 48 ++++
 rtl/control_pipe_gen.sv | 111 +++++++++++
 4 files changed

// File: rtl/control_pipe_gen_pkg.sv
// Shared types and encodings for the control pipeline generator: opcodes,
// result-select codes, the 9-bit control bundle and the decoder result.
package control_pipe_gen_pkg;

    localparam int CTRL_W = 9;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] RES_ALU   = 3'b000;
    localparam logic [2:0] RES_IMM   = 3'b001;
    localparam logic [2:0] RES_PCIMM = 3'b010;
    localparam logic [2:0] RES_PC4   = 3'b011;
    localparam logic [2:0] RES_LOAD  = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [2:0] res_sel;
    } ctrl_t;

    typedef enum logic [1:0] {
        U_OTHER = 2'b00,
        U_LUI   = 2'b01,
        U_AUIPC = 2'b10
    } u_ctrl_e;

    typedef struct packed {
        ctrl_t   ctrl;
        logic    legal;
        u_ctrl_e u;
    } dec_t;

    // flags = {reg_write,mem_write,mem_read,branch,jump,alu_src}
    function automatic ctrl_t mk_ctrl(input logic [5:0] flags, input logic [2:0] res);
        return {flags, res};
    endfunction

endpackage

// File: rtl/control_pipe_gen_if.sv
// Decode-stage instruction handshake: producer drives valid/opcode/funct3,
// the control pipe answers with ready.
interface control_pipe_gen_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode_d;
    logic [2:0] funct3_d;

    modport master (output in_valid, opcode_d, funct3_d, input in_ready);
    modport slave  (input in_valid, opcode_d, funct3_d, output in_ready);
endinterface

// File: rtl/control_pipe_gen_decode.sv
// Combinational opcode/funct3 decoder producing the control bundle, a legality
// flag and the legacy U_control code.
module control_pipe_gen_decode
    import control_pipe_gen_pkg::*;
#(
    parameter bit FENCE_OK = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (opcode_i)
            OPC_R:      begin dec_o.ctrl = mk_ctrl(6'b100000, RES_ALU); dec_o.legal = 1'b1; end
            OPC_I:      begin dec_o.ctrl = mk_ctrl(6'b100001, RES_ALU); dec_o.legal = 1'b1; end
            OPC_LOAD: begin
                dec_o.ctrl  = mk_ctrl(6'b101001, RES_LOAD);
                dec_o.legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                dec_o.ctrl  = mk_ctrl(6'b010001, RES_ALU);
                dec_o.legal = funct3_i inside {3'b000, 3'b001, 3'b010};
            end
            OPC_BRANCH: begin
                dec_o.ctrl  = mk_ctrl(6'b000100, RES_ALU);
                dec_o.legal = !(funct3_i inside {3'b010, 3'b011});
            end
            OPC_JAL:    begin dec_o.ctrl = mk_ctrl(6'b100010, RES_PC4); dec_o.legal = 1'b1; end
            OPC_JALR:   begin dec_o.ctrl = mk_ctrl(6'b100011, RES_PC4); dec_o.legal = 1'b1; end
            OPC_LUI: begin
                dec_o.ctrl  = mk_ctrl(6'b100001, RES_IMM);
                dec_o.legal = 1'b1;
                dec_o.u     = U_LUI;
            end
            OPC_AUIPC: begin
                dec_o.ctrl  = mk_ctrl(6'b100001, RES_PCIMM);
                dec_o.legal = 1'b1;
                dec_o.u     = U_AUIPC;
            end
            // FENCE travels as a valid all-zero bundle (a NOP)
            OPC_FENCE:  dec_o.legal = FENCE_OK;
            default:    dec_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_pipe_gen.sv
// Control generator: decodes the D-stage instruction and carries the bundle
// through NUM_STAGES registered stages with stall/flush, plus illegal tracking.
module control_pipe_gen
    import control_pipe_gen_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 8,
    parameter bit FENCE_OK   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    control_pipe_gen_if.slave            in_if,
    input  logic                         stall,
    input  logic                         flush,
    output logic [NUM_STAGES-1:0]        ctrl_valid,
    output logic [NUM_STAGES*CTRL_W-1:0] ctrl_bus,
    output logic [1:0]                   u_control_e,
    output logic                         illegal_o,
    output logic [CNT_W-1:0]             illegal_cnt
);

    localparam bit S0_KILL = (NUM_STAGES > 1);

    dec_t  dec;
    logic  accept;
    logic  in_vld;
    ctrl_t in_bus;

    control_pipe_gen_decode #(.FENCE_OK(FENCE_OK)) u_decode (
        .opcode_i (in_if.opcode_d),
        .funct3_i (in_if.funct3_d),
        .dec_o    (dec)
    );

    assign in_if.in_ready = ~stall;
    assign accept = in_if.in_valid & ~stall & ~flush;
    assign in_vld = accept & dec.legal;
    assign in_bus = in_vld ? dec.ctrl : '0;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Every stage but W is younger than W and dies on flush, even under stall
        localparam bit KILL = (k < NUM_STAGES - 1);
        logic  prev_v, v_d, v_q;
        ctrl_t prev_b, b_d, b_q;

        if (k == 0) begin : g_head
            assign prev_v = in_vld;
            assign prev_b = in_bus;
        end else begin : g_body
            assign prev_v = ctrl_valid[k-1];
            assign prev_b = ctrl_bus[CTRL_W*(k-1) +: CTRL_W];
        end

        always_comb begin
            v_d = v_q;
            b_d = b_q;
            if (KILL && flush) begin
                v_d = 1'b0;
                b_d = '0;
            end else if (!stall) begin
                v_d = prev_v;
                b_d = prev_b;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                b_q <= '0;
            end else begin
                v_q <= v_d;
                b_q <= b_d;
            end
        end

        assign ctrl_valid[k]                  = v_q;
        assign ctrl_bus[CTRL_W*k +: CTRL_W]   = b_q;
    end

    // Legacy U_control shadows stage 0 with the same hold/kill rules
    u_ctrl_e          u_d, u_q;
    logic             ill_d, ill_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        u_d = u_q;
        if (S0_KILL && flush)  u_d = U_OTHER;
        else if (!stall)       u_d = in_vld ? dec.u : U_OTHER;

        ill_d = accept & ~dec.legal;
        cnt_d = cnt_q;
        if (ill_d && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u_q   <= U_OTHER;
            ill_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            u_q   <= u_d;
            ill_q <= ill_d;
            cnt_q <= cnt_d;
        end
    end

    assign u_control_e = u_q;
    assign illegal_o   = ill_q;
    assign illegal_cnt = cnt_q;

endmodule
